// File: rtl/seq_stage_controller.sv
// seq_stage_controller: one-hot-by-state stage sequencer for the SEQ Y86-64 core.
// Define SEQ_CTRL_SINGLE_STEP_EN to add a step input and return to IDLE after each instruction.
module seq_stage_controller #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SEQ_CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             start,
    input  logic [3:0]       Ins_Code,
    input  logic             instruction_invalid_check,
    input  logic             mem_invalid_check,
    input  logic             mem_ready,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             mem_req,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT} state_t;
    state_t state, next;
    logic [2:0] stat_next;
    logic [WW-1:0] wait_cnt;
    logic retire, is_mem, go;
    state_t after_pc;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
    assign go = start | step;
    assign after_pc = IDLE;
`else
    assign go = start;
    assign after_pc = FETCH;
`endif
    assign is_mem = Ins_Code inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    always_comb begin
        next = state;
        stat_next = stat;
        retire = 1'b0;
        case (state)
            IDLE: next = go ? FETCH : IDLE;
            FETCH: begin
                if (mem_invalid_check) begin
                    next = HALT;
                    stat_next = ADR;
                end else if (instruction_invalid_check) begin
                    next = HALT;
                    stat_next = INS;
                end else if (Ins_Code == 4'd0) begin
                    next = HALT;
                    stat_next = HLT;
                    retire = 1'b1;
                end else begin
                    next = DECODE;
                end
            end
            DECODE: next = EXECUTE;
            EXECUTE: next = MEMORY;
            MEMORY: begin
                // A data-memory fault wins over a simultaneous ready so write-back never sees bad data
                if (!is_mem || (!mem_invalid_check && mem_ready)) begin
                    next = WRITEBACK;
                end else if (mem_invalid_check || wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                    next = HALT;
                    stat_next = ADR;
                end
            end
            WRITEBACK: next = PCUPD;
            PCUPD: begin
                next = after_pc;
                retire = 1'b1;
            end
            HALT: next = HALT;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            stat <= AOK;
            wait_cnt <= '0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            state <= next;
            stat <= stat_next;
            wait_cnt <= (state == MEMORY) ? wait_cnt + 1'b1 : '0;
            if (state != IDLE && state != HALT && !(&cycle_count))
                cycle_count <= cycle_count + 1'b1;
            if (retire && !(&instr_count))
                instr_count <= instr_count + 1'b1;
        end
    end
    assign fetch_en = state == FETCH;
    assign decode_en = state == DECODE;
    assign execute_en = state == EXECUTE;
    assign mem_req = state == MEMORY && is_mem;
    assign wb_en = state == WRITEBACK;
    assign pc_en = state == PCUPD;
    assign halted = state == HALT;
endmodule
